ff_net_driver: RTL and testbench

//  Bus initiator for the ff_network register interface. Pulls weight words (optional)
//  and input words from a valid/ready source and writes them into the network.

---
 rtl/ff_net_pkg.sv | 36 +++
 rtl/ff_net_timeout.sv | 37 +++
 rtl/ff_net_driver.sv | 164 ++++++++++++++++
 tb/tb_ff_net_driver.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ff_net_pkg.sv
// rtl/ff_net_pkg.sv - shared FSM states, address map and sizing helpers for ff_net_driver
package ff_net_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_I,
    WAIT_DOWN,
    READ_O,
    DONE,
    ABORT
  } state_t;

  localparam int DEF_LENGHT_I   = 8;
  localparam int DEF_LENGHT_MID = 4;
  localparam int DEF_LENGHT_O   = 2;
  localparam int W_BASE         = 0;

  function automatic int calc_nw(input int li, input int lm, input int lo);
    return li * lm + lm * lo;
  endfunction

  // One spare address separates each region of the network register map.
  function automatic int calc_i_base(input int li, input int lm, input int lo);
    return calc_nw(li, lm, lo) + 1;
  endfunction

  function automatic int calc_o_base(input int li, input int lm, input int lo);
    return calc_nw(li, lm, lo) + li + 2;
  endfunction

  function automatic int calc_addr_w(input int li, input int lm, input int lo);
    return $clog2(calc_o_base(li, lm, lo) + lo);
  endfunction

endpackage

// File: rtl/ff_net_timeout.sv
// rtl/ff_net_timeout.sv - saturating no-progress cycle counter with clear/enable and hit flag
module ff_net_timeout #(
  parameter int  TIMEOUT = 1023,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Flags the cycle that completes TIMEOUT idle cycles, so the abort lands on the next one.
  assign hit_o = en_i && !clr_i && (cnt_d == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ff_net_driver.sv
// rtl/ff_net_driver.sv - bus initiator loading weights/inputs into ff_network and streaming its outputs back
module ff_net_driver
  import ff_net_pkg::*;
#(
  parameter int  WIDTH      = 32,
  parameter int  LENGHT_I   = DEF_LENGHT_I,
  parameter int  LENGHT_MID = DEF_LENGHT_MID,
  parameter int  LENGHT_O   = DEF_LENGHT_O,
  parameter int  TIMEOUT    = 1023,
  localparam int WIDTH_ADDR = calc_addr_w(LENGHT_I, LENGHT_MID, LENGHT_O),
  localparam int IDX_W      = (LENGHT_O > 1) ? $clog2(LENGHT_O) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  reload_w,
  input  logic                  src_valid,
  input  logic [WIDTH-1:0]      src_data,
  output logic                  src_ready,
  output logic                  res_valid,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDX_W-1:0]      res_idx,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  bus_write,
  output logic                  bus_read,
  output logic [WIDTH_ADDR-1:0] bus_addr,
  output logic [WIDTH-1:0]      bus_wdata,
  input  logic [WIDTH-1:0]      bus_rdata,
  input  logic                  net_ready,
  input  logic                  net_down
);

  localparam int NW = calc_nw(LENGHT_I, LENGHT_MID, LENGHT_O);
  localparam logic [WIDTH_ADDR-1:0] W_BASE_A = WIDTH_ADDR'(W_BASE);
  localparam logic [WIDTH_ADDR-1:0] I_BASE_A = WIDTH_ADDR'(calc_i_base(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] O_BASE_A = WIDTH_ADDR'(calc_o_base(LENGHT_I, LENGHT_MID, LENGHT_O));
  localparam logic [WIDTH_ADDR-1:0] W_LAST   = WIDTH_ADDR'(NW - 1);
  localparam logic [WIDTH_ADDR-1:0] I_LAST   = WIDTH_ADDR'(LENGHT_I - 1);
  localparam logic [WIDTH_ADDR-1:0] O_LAST   = WIDTH_ADDR'(LENGHT_O - 1);

  state_t                state_q, state_d;
  logic [WIDTH_ADDR-1:0] cnt_q, cnt_d;
  logic                  res_valid_q;
  logic [IDX_W-1:0]      res_idx_q;
  logic                  loading, reading, handshake, progress, timed, tmo_hit;

  always_comb begin
    loading   = (state_q == LOAD_W) || (state_q == LOAD_I);
    reading   = (state_q == READ_O);
    src_ready = loading && net_ready;
    handshake = src_ready && src_valid;
    progress  = handshake || reading || ((state_q == WAIT_DOWN) && net_down);
    timed     = loading || reading || (state_q == WAIT_DOWN);
  end

  ff_net_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk  (clk),
    .rst_n(reset),
    .clr_i(progress || !timed),
    .en_i (timed),
    .hit_o(tmo_hit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = reload_w ? LOAD_W : LOAD_I;
          cnt_d   = '0;
        end
      end
      LOAD_W: begin
        if (handshake) begin
          if (cnt_q == W_LAST) begin
            state_d = LOAD_I;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = ABORT;
        end
      end
      LOAD_I: begin
        if (handshake) begin
          if (cnt_q == I_LAST) begin
            state_d = WAIT_DOWN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else if (tmo_hit) begin
          state_d = ABORT;
        end
      end
      // Level-sensitive: a net_down already high on entry still costs one cycle here.
      WAIT_DOWN: begin
        if (net_down) begin
          state_d = READ_O;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = ABORT;
        end
      end
      READ_O: begin
        if (cnt_q == O_LAST) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE, ABORT: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus_write = handshake;
    bus_read  = reading;
    bus_wdata = handshake ? src_data : '0;
    bus_addr  = '0;
    if (handshake) begin
      bus_addr = ((state_q == LOAD_W) ? W_BASE_A : I_BASE_A) + cnt_q;
    end else if (reading) begin
      bus_addr = O_BASE_A + cnt_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      res_valid_q <= reading;
      res_idx_q   <= reading ? IDX_W'(cnt_q) : '0;
    end
  end

  // Read data arrives the cycle after bus_read, which is exactly when res_valid is up.
  assign res_valid = res_valid_q;
  assign res_idx   = res_idx_q;
  assign res_data  = res_valid_q ? bus_rdata : '0;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign timeout   = (state_q == ABORT);

endmodule

// File: tb/tb_ff_net_driver.sv
// tb/tb_ff_net_driver.sv - table-driven scoreboard bench for ff_net_driver
`timescale 1ns/1ps
module tb_ff_net_driver;

  localparam int LI     = 8;
  localparam int LM     = 4;
  localparam int LO     = 2;
  localparam int TMO    = 15;
  localparam int NW     = LI * LM + LM * LO;
  localparam int AW     = 6;
  localparam int I_BASE = NW + 1;
  localparam int O_BASE = NW + LI + 2;

  logic          clk = 1'b0;
  logic          rst_n, start, reload_w, src_valid, src_ready;
  logic [31:0]   src_data, res_data, bus_wdata, bus_rdata;
  logic          res_valid, busy, done, timeout, bus_write, bus_read, net_ready, net_down;
  logic [0:0]    res_idx;
  logic [AW-1:0] bus_addr;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic [0:0]  idx;
    logic [31:0] data;
  } res_t;

  typedef struct {
    bit rw;
    bit nr_toggle;
    bit gaps;
    int down_delay;
    int restart_at;
    bit exp_done;
  } job_t;

  wr_t           wq[$];
  logic [AW-1:0] rq[$];
  res_t          resq[$];
  int n_chk = 0;
  int n_fail = 0;
  int done_seen = 0;
  int to_seen = 0;
  int cycle_n = 0;
  int last_wr_cyc = 0;
  int to_cyc = 0;
  job_t jobs[6];

  always #5 clk = ~clk;

  ff_net_driver #(
    .WIDTH     (32),
    .LENGHT_I  (LI),
    .LENGHT_MID(LM),
    .LENGHT_O  (LO),
    .TIMEOUT   (TMO)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .start    (start),
    .reload_w (reload_w),
    .src_valid(src_valid),
    .src_data (src_data),
    .src_ready(src_ready),
    .res_valid(res_valid),
    .res_data (res_data),
    .res_idx  (res_idx),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout),
    .bus_write(bus_write),
    .bus_read (bus_read),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .net_ready(net_ready),
    .net_down (net_down)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i, input bit rw);
    if (rw && i < NW) return 32'h1000_0000 + 32'(i);
    return 32'h2000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] net_value(input int addr);
    return 32'hC0DE_0000 | 32'(addr);
  endfunction

  // Network read model: data for the address read last cycle.
  always @(posedge clk) begin
    cycle_n   <= cycle_n + 1;
    bus_rdata <= bus_read ? net_value(int'(bus_addr)) : 32'h0;
  end

  always @(negedge clk) begin : mon
    wr_t  e;
    res_t r;
    if (rst_n) begin
      if (!net_ready) chk("src_ready_gated", src_ready, 0);
      if (bus_write) begin
        chk("rd_wr_exclusive", bus_read, 0);
        chk("write_net_ready", net_ready, 1);
        if (wq.size() == 0) begin
          chk("unexpected_write", bus_write, 0);
        end else begin
          e = wq.pop_front();
          chk("wr_addr", bus_addr, e.addr);
          chk("wr_data", bus_wdata, e.data);
        end
        last_wr_cyc = cycle_n;
      end
      if (bus_read) begin
        if (rq.size() == 0) chk("unexpected_read", bus_read, 0);
        else chk("rd_addr", bus_addr, rq.pop_front());
      end
      if (res_valid) begin
        if (resq.size() == 0) begin
          chk("unexpected_res", res_valid, 0);
        end else begin
          r = resq.pop_front();
          chk("res_idx", res_idx, r.idx);
          chk("res_data", res_data, r.data);
          if (res_idx == 1'(LO - 1)) chk("done_with_last_res", done, 1);
        end
      end
      if (done) done_seen++;
      if (timeout) begin
        to_seen++;
        to_cyc = cycle_n;
      end
    end
  end

  task automatic load_phase(input job_t j);
    int total, idx, cyc;
    bit took;
    wr_t e;
    total = j.rw ? NW + LI : LI;
    for (int i = 0; i < total; i++) begin
      e.addr = (j.rw && i < NW) ? AW'(i) : AW'(I_BASE + i - (j.rw ? NW : 0));
      e.data = word(i, j.rw);
      wq.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; reload_w = j.rw;
    @(posedge clk); #1;
    start = 1'b0; reload_w = 1'b0;
    idx = 0; cyc = 0;
    while (idx < total && cyc < 1000) begin
      net_ready = j.nr_toggle ? ((cyc % 2) == 0) : 1'b1;
      src_valid = !(j.gaps && (cyc % 3 == 2));
      src_data  = word(idx, j.rw);
      start     = (idx == j.restart_at);
      reload_w  = start;
      @(negedge clk);
      took = src_valid && src_ready;
      @(posedge clk); #1;
      if (took) idx++;
      cyc++;
    end
    start = 1'b0; reload_w = 1'b0; src_valid = 1'b0; src_data = '0; net_ready = 1'b1;
    chk("load_words", idx, total);
  endtask

  task automatic run_job(input job_t j);
    int cyc;
    res_t r;
    done_seen = 0; to_seen = 0;
    if (j.exp_done) begin
      for (int k = 0; k < LO; k++) begin
        rq.push_back(AW'(O_BASE + k));
        r.idx  = 1'(k);
        r.data = net_value(O_BASE + k);
        resq.push_back(r);
      end
    end
    load_phase(j);
    if (j.down_delay >= 0) begin
      repeat (j.down_delay) begin
        @(posedge clk); #1;
      end
      net_down = 1'b1;
    end
    cyc = 0;
    while (done_seen == 0 && to_seen == 0 && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
    #1 net_down = 1'b0;
    chk("job_end_in_time", (cyc < 200), 1);
    chk("done_pulses", done_seen, j.exp_done ? 1 : 0);
    chk("timeout_pulses", to_seen, j.exp_done ? 0 : 1);
    if (!j.exp_done) chk("timeout_latency", to_cyc - last_wr_cyc, TMO + 1);
    @(negedge clk);
    chk("busy_after_job", busy, 0);
    chk("wq_drained", wq.size(), 0);
    chk("rq_drained", rq.size(), 0);
    chk("resq_drained", resq.size(), 0);
  endtask

  task automatic reset_mid_read();
    job_t j;
    int cyc;
    j = '{1'b0, 1'b0, 1'b0, 0, -1, 1'b1};
    done_seen = 0; to_seen = 0;
    load_phase(j);
    rq.push_back(AW'(O_BASE));
    net_down = 1'b1;
    cyc = 0;
    while (!bus_read && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_read", bus_read, 1);
    #1 rst_n = 1'b0;
    net_down = 1'b0;
    @(negedge clk);
    chk("reset_mid_outputs", |{src_ready, res_valid, res_data, res_idx, busy, done, timeout,
                                bus_write, bus_read, bus_addr, bus_wdata}, 0);
    chk("reset_mid_no_done", done_seen + to_seen, 0);
    chk("reset_mid_rq", rq.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("after_reset_idle", busy, 0);
    chk("after_reset_no_done", done_seen, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; reload_w = 1'b0; src_valid = 1'b0; src_data = '0;
    net_ready = 1'b1; net_down = 1'b0;
    //         rw    toggle gaps  delay restart done
    jobs[0] = '{1'b1, 1'b0, 1'b0, 2,    -1,     1'b1};
    jobs[1] = '{1'b0, 1'b0, 1'b0, 5,    -1,     1'b1};
    jobs[2] = '{1'b1, 1'b1, 1'b0, 0,    -1,     1'b1};
    jobs[3] = '{1'b0, 1'b0, 1'b0, -1,   -1,     1'b0};
    jobs[4] = '{1'b0, 1'b0, 1'b1, 3,    3,      1'b1};
    jobs[5] = '{1'b0, 1'b1, 1'b1, 1,    -1,     1'b1};
    repeat (2) @(negedge clk);
    chk("reset_outputs", |{src_ready, res_valid, res_data, res_idx, busy, done, timeout,
                           bus_write, bus_read, bus_addr, bus_wdata}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    src_valid = 1'b1;
    @(negedge clk);
    chk("idle_src_ready", src_ready, 0);
    chk("idle_busy", busy, 0);
    @(posedge clk); #1;
    src_valid = 1'b0;
    for (int t = 0; t < 6; t++) run_job(jobs[t]);
    reset_mid_read();
    run_job(jobs[1]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
